// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style main controller.
// A Moore FSM sequences fetch/decode/execute/writeback. The only Mealy terms are
// the mem_ready-qualified fetch/store signals and the zero-qualified branch PC write.
// While rst is low every output is forced to zero.
module mc_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       IsJal,
  output logic       IsLui,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StWbMem   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StWbR     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StJal     = 4'd10,
    StExecI   = 4'd11,
    StWbI     = 4'd12,
    StLui     = 4'd13,
    StJr      = 4'd14,
    StHalt    = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       is_jal;
    logic       is_lui;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLui   = 6'b001111;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  state_e state_q, state_d;
  state_e illegal_next;
  logic   r_legal;
  logic [3:0] r_alu_op;
  ctrl_t  ctrl, ctrl_g;

  assign illegal_next = ILLEGAL_HALT ? StHalt : StFetch;

  // R-type funct decode: ALU operation and legality.
  always_comb begin
    r_legal  = 1'b1;
    r_alu_op = AluAdd;
    case (funct)
      FnAdd:   r_alu_op = AluAdd;
      FnSub:   r_alu_op = AluSub;
      FnAnd:   r_alu_op = AluAnd;
      FnOr:    r_alu_op = AluOr;
      FnSlt:   r_alu_op = AluSlt;
      default: r_legal  = 1'b0;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpRtype:      state_d = (funct == FnJr) ? StJr : StExecR;
          OpLw, OpSw:   state_d = StMemAddr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          OpJal:        state_d = StJal;
          OpAddi:       state_d = StExecI;
          OpLui:        state_d = StLui;
          default:      state_d = illegal_next;
        endcase
      end
      StMemAddr: begin
        if (opcode == OpLw)      state_d = StMemRd;
        else if (opcode == OpSw) state_d = StMemWr;
        else                     state_d = illegal_next;
      end
      StMemRd: begin
        if (mem_ready) state_d = StWbMem;
      end
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
      end
      StExecR: state_d = r_legal ? StWbR : illegal_next;
      StExecI: state_d = StWbI;
      StHalt:  state_d = StHalt;
      // Final cycle of every other instruction class.
      default: state_d = StFetch;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = AluAdd;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = AluAdd;
      end
      StMemAddr, StExecI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = AluAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StWbMem: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      StExecR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = r_alu_op;
      end
      StWbR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = AluSub;
        ctrl.pc_source     = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        // opcode bit 0 separates bne from beq
        ctrl.pc_write      = opcode[0] ? ~zero : zero;
        ctrl.instr_done    = 1'b1;
      end
      StJump: begin
        ctrl.pc_source  = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StJal: begin
        ctrl.pc_source  = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.is_jal     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StWbI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StLui: begin
        ctrl.reg_write  = 1'b1;
        ctrl.is_lui     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StJr: begin
        ctrl.pc_source  = 2'b11;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StHalt: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset forces every output low, including mid-transfer strobes.
  assign ctrl_g = rst ? ctrl : '0;
  assign state  = rst ? state_q : 4'd0;

  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.i_or_d;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign IRWrite     = ctrl_g.ir_write;
  assign MemToReg    = ctrl_g.mem_to_reg;
  assign RegDst      = ctrl_g.reg_dst;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign IsJal       = ctrl_g.is_jal;
  assign IsLui       = ctrl_g.is_lui;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign PCSource    = ctrl_g.pc_source;
  assign ALUOp       = ctrl_g.alu_op;
  assign instr_done  = ctrl_g.instr_done;
  assign halted      = ctrl_g.halted;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: each instruction is expanded into its
// expected state walk (including wait cycles) and every cycle's outputs are
// compared with the control word the instruction class calls for.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, IsJal, IsLui;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic       instr_done, halted;
  logic [3:0] state;
  logic [25:0] obs;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mc_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .IsJal(IsJal), .IsLui(IsLui),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .instr_done(instr_done),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                RegWrite, ALUSrcA, IsJal, IsLui, ALUSrcB, PCSource, ALUOp, instr_done,
                halted, state};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] alu_for(input logic [5:0] fn);
    case (fn)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2a:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // Control word required in a given state for the given inputs.
  function automatic logic [25:0] exp_ctrl(input int st, input logic mr, input logic z,
                                           input logic [5:0] op, input logic [5:0] fn);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal, lui, dn, hl;
    logic [1:0] asb, pcs;
    logic [3:0] aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal, lui, dn, hl} = '0;
    asb = 2'd0; pcs = 2'd0; aop = 4'd0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; aop = 4'b0010; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; aop = 4'b0010; end
      2:  begin asa = 1; asb = 2'b10; aop = 4'b0010; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mwr = 1; iord = 1; dn = mr; end
      6:  begin asa = 1; aop = alu_for(fn); end
      7:  begin rw = 1; rdst = 1; dn = 1; end
      8:  begin
            asa = 1; aop = 4'b0110; pcs = 2'b01; pcwc = 1; dn = 1;
            pcw = (op == 6'h04) ? z : !z;
          end
      9:  begin pcs = 2'b10; pcw = 1; dn = 1; end
      10: begin pcs = 2'b10; pcw = 1; rw = 1; jal = 1; dn = 1; end
      11: begin asa = 1; asb = 2'b10; aop = 4'b0010; end
      12: begin rw = 1; dn = 1; end
      13: begin rw = 1; lui = 1; dn = 1; end
      14: begin pcs = 2'b11; pcw = 1; dn = 1; end
      15: hl = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal, lui, asb, pcs, aop,
            dn, hl, 4'(st)};
  endfunction

  // Run one legal instruction: wf fetch wait cycles, wm data-memory wait cycles.
  // zf < 0 drives a random zero flag each cycle, otherwise zf is the fixed value.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                           input int wm, input int zf);
    int  seq[$];
    bit  rdy[$];
    int  lat;
    int  done_at;
    repeat (wf) begin seq.push_back(0); rdy.push_back(1'b0); end
    seq.push_back(0); rdy.push_back(1'b1);
    seq.push_back(1); rdy.push_back(1'($urandom));
    case (op)
      6'h00: begin
        if (fn == 6'h08) begin seq.push_back(14); rdy.push_back(1'($urandom)); end
        else begin
          seq.push_back(6); rdy.push_back(1'($urandom));
          seq.push_back(7); rdy.push_back(1'($urandom));
        end
      end
      6'h23, 6'h2b: begin
        int ms;
        ms = (op == 6'h23) ? 3 : 5;
        seq.push_back(2); rdy.push_back(1'($urandom));
        repeat (wm) begin seq.push_back(ms); rdy.push_back(1'b0); end
        seq.push_back(ms); rdy.push_back(1'b1);
        if (op == 6'h23) begin seq.push_back(4); rdy.push_back(1'($urandom)); end
      end
      6'h04, 6'h05: begin seq.push_back(8); rdy.push_back(1'($urandom)); end
      6'h02: begin seq.push_back(9); rdy.push_back(1'($urandom)); end
      6'h03: begin seq.push_back(10); rdy.push_back(1'($urandom)); end
      6'h08: begin
        seq.push_back(11); rdy.push_back(1'($urandom));
        seq.push_back(12); rdy.push_back(1'($urandom));
      end
      default: begin seq.push_back(13); rdy.push_back(1'($urandom)); end
    endcase
    if (op == 6'h23) lat = 5;
    else if ((op == 6'h00 && fn != 6'h08) || op == 6'h2b || op == 6'h08) lat = 4;
    else lat = 3;
    if (op == 6'h23 || op == 6'h2b) lat += wm;
    lat += wf;
    done_at = -1;
    foreach (seq[i]) begin
      @(negedge clk);
      if (i == 0) begin opcode = op; funct = fn; end
      mem_ready = rdy[i];
      zero = (zf < 0) ? 1'($urandom) : 1'(zf);
      #1;
      check_eq($sformatf("op%02h_fn%02h_cyc%0d", op, fn, i), 32'(obs),
               32'(exp_ctrl(seq[i], mem_ready, zero, op, fn)));
      check_eq("mem_rw_excl", 32'({MemRead & MemWrite, RegWrite & MemWrite}), 32'd0);
      if (instr_done && done_at < 0) done_at = i;
    end
    check_eq($sformatf("latency_op%02h", op), 32'(done_at + 1), 32'(lat));
  endtask

  // Illegal instruction: expect HALT for 10 cycles, then a one-cycle reset.
  task automatic halt_test(input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk); opcode = op; funct = fn; mem_ready = 1'b1; zero = 1'b0; #1;
    check_eq("halt_fetch", 32'(obs), 32'(exp_ctrl(0, 1'b1, 1'b0, op, fn)));
    @(negedge clk); mem_ready = 1'($urandom); #1;
    check_eq("halt_decode", 32'(obs), 32'(exp_ctrl(1, mem_ready, zero, op, fn)));
    if (op == 6'h00) begin
      @(negedge clk); #1;
      check_eq("halt_exec_r_state", 32'(state), 32'd6);
    end
    repeat (10) begin
      @(negedge clk); mem_ready = 1'($urandom); zero = 1'($urandom); #1;
      check_eq("halted_state", 32'(obs), 32'(exp_ctrl(15, mem_ready, zero, op, fn)));
    end
    @(negedge clk); rst = 1'b0; #1;
    check_eq("halt_rst_outputs", 32'(obs), 32'd0);
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
    check_eq("halt_rst_exit", 32'(obs), 32'(exp_ctrl(0, 1'b0, zero, op, fn)));
  endtask

  // Reset while a data-memory transfer is stalled.
  task automatic reset_mid_mem(input logic [5:0] op);
    int ms;
    ms = (op == 6'h23) ? 3 : 5;
    @(negedge clk); opcode = op; funct = 6'h00; mem_ready = 1'b1; #1;
    check_eq("rmm_fetch", 32'(obs), 32'(exp_ctrl(0, 1'b1, zero, op, 6'h00)));
    @(negedge clk); #1;
    check_eq("rmm_decode", 32'(obs), 32'(exp_ctrl(1, 1'b1, zero, op, 6'h00)));
    @(negedge clk); mem_ready = 1'b0; #1;
    check_eq("rmm_addr", 32'(obs), 32'(exp_ctrl(2, 1'b0, zero, op, 6'h00)));
    @(negedge clk); #1;
    check_eq("rmm_wait", 32'(obs), 32'(exp_ctrl(ms, 1'b0, zero, op, 6'h00)));
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rmm_rst_outputs", 32'(obs), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    check_eq("rmm_rst_exit", 32'(obs), 32'(exp_ctrl(0, 1'b0, zero, op, 6'h00)));
  endtask

  logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0f};
  logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};

  initial begin
    rst = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
    check_eq("reset_release", 32'(obs), 32'(exp_ctrl(0, 1'b0, 1'b0, 6'h00, 6'h20)));

    // Directed scenarios.
    run_instr(6'h00, 6'h20, 0, 0, -1);
    run_instr(6'h23, 6'h00, 0, 2, -1);
    run_instr(6'h04, 6'h00, 0, 0, 1);
    run_instr(6'h05, 6'h00, 0, 0, 1);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h03, 6'h00, 0, 0, -1);
    run_instr(6'h2b, 6'h00, 1, 3, -1);
    halt_test(6'h3f, 6'h00);
    halt_test(6'h00, 6'h3f);
    reset_mid_mem(6'h2b);
    reset_mid_mem(6'h23);

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 8)];
      fn = fns[$urandom_range(0, 5)];
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: ILLEGAL_HALT, default 1, meaning: 1 = unknown opcode/funct enters HALT; 0 = treated as NOP (returns to FETCH).
REQ-002 Port: clk  input  1  rising-edge clock, the only clock.
REQ-003 Port: rst  input  1  synchronous active-low reset; sampled on the rising edge of clk only.
REQ-004 Port: opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 Port: funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 Port: zero  input  1  ALU zero flag.
REQ-007 Port: mem_ready  input  1  memory handshake; high = current read/write completes this cycle.
REQ-008 Ports, each output 1: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, IsJal, IsLui.
REQ-009 Ports: ALUSrcB output 2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2); PCSource output 2 (00 ALU result, 01 ALUOut, 10 jump target, 11 reg A); ALUOp output 4.
REQ-010 Ports: instr_done output 1 (one-cycle pulse on the final cycle of each instruction); halted output 1; state output 4 (current state encoding, debug).

Function
REQ-011 ALUOp codes SHALL be AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-012 States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, WB_MEM 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, JAL 10, EXEC_I 11, WB_I 12, LUI 13, JR 14, HALT 15.
REQ-013 Outputs are Moore decodes of state, except PCWrite in BRANCH and MemRead/MemWrite/IRWrite qualification below; unlisted outputs are 0 in each state.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00; IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0, goes to DECODE when mem_ready=1.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut); next state by opcode: 000000 -> EXEC_R (funct 001000 -> JR); 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010 -> JUMP; 000011 -> JAL; 001000 -> EXEC_I; 001111 -> LUI; other -> HALT if ILLEGAL_HALT=1 else FETCH.
REQ-016 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD; -> MEM_RD for 100011, MEM_WR for 101011.
REQ-017 MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1, then -> WB_MEM. WB_MEM: RegWrite=1, MemToReg=1, RegDst=0, instr_done=1; -> FETCH.
REQ-018 MEM_WR: MemWrite=1, IorD=1; hold until mem_ready=1; on that cycle instr_done=1, -> FETCH.
REQ-019 EXEC_R: ALUSrcA=1, ALUSrcB=00; ALUOp by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; other funct -> HALT/FETCH per ILLEGAL_HALT instead of WB_R. WB_R: RegWrite=1, RegDst=1, MemToReg=0, instr_done=1; -> FETCH.
REQ-020 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD; -> WB_I. WB_I: RegWrite=1, RegDst=0, instr_done=1; -> FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWriteCond=1; PCWrite=zero for beq, ~zero for bne; instr_done=1; -> FETCH.
REQ-022 JUMP: PCSource=10, PCWrite=1, instr_done=1. JAL: as JUMP plus RegWrite=1, IsJal=1 (rd=31, data=PC). JR: PCSource=11, PCWrite=1, instr_done=1. LUI: RegWrite=1, IsLui=1, RegDst=0, instr_done=1. All -> FETCH.
REQ-023 Latency with mem_ready always 1: lw 5, R-type/addi/sw 4, beq/bne/j/jal/jr/lui 3 cycles; each wait cycle with mem_ready=0 adds exactly one cycle.
REQ-024 HALT: all control outputs 0, halted=1, state held until reset.
REQ-025 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite and MemWrite SHALL never be 1 in the same cycle.
REQ-026 mem_ready in any state other than FETCH/MEM_RD/MEM_WR is ignored.

Reset
REQ-027 rst=0 at a rising edge -> state=FETCH next cycle, regardless of current state (including mid-wait in MEM_RD/MEM_WR and HALT).
REQ-028 While rst=0 all outputs are 0 (MemRead, IRWrite, PCWrite included), instr_done=0, halted=0.
REQ-029 First cycle after rst returns high: FETCH with MemRead=1.

Verification
REQ-030 Reset release, opcode=000000 funct=100000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 RegDst=1 only in state 7; instr_done pulse in cycle 4.
REQ-031 lw (100011), mem_ready low 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; MemRead=1 IorD=1 for 3 cycles; total 7 cycles.
REQ-032 beq with zero=1 -> PCWrite=1 PCSource=01 in BRANCH; bne with zero=1 -> PCWrite=0, PCWriteCond=1.
REQ-033 jal (000011) -> states 0,1,10; in state 10 PCWrite=1 PCSource=10 RegWrite=1 IsJal=1.
REQ-034 opcode=111111, ILLEGAL_HALT=1 -> state 15, halted=1, all controls 0 for 10 cycles; rst=0 one cycle -> state 0.
REQ-035 rst=0 asserted while in MEM_WR with mem_ready=0 -> MemWrite=0 that cycle, state 0 next cycle, no instr_done pulse.
